// File: rtl/contador_monitor.sv
// Receive-side checker for the 4-bit mode counter bus: predicts the next Q/RCO
// from the previous edge's controls and observed Q, and flags/counts mismatches.
module contador_monitor #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8
) (
    input  logic             CLK,
    input  logic             RESET_L,
    input  logic             ENB,
    input  logic [1:0]       MODO,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] Q,
    input  logic             RCO,
    output logic             ARMED,
    output logic             ERR,
    output logic             ERR_Q,
    output logic             ERR_RCO,
    output logic             ERR_STICKY,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic [ERR_W-1:0] CHK_CNT,
    output logic [WIDTH-1:0] EXP_Q
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WARM  = 2'b01,
        CHECK = 2'b10
    } state_t;

    localparam logic [WIDTH-1:0] MAX_Q = '1;
    localparam logic [ERR_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic             pEnb_q;
    logic [1:0]       pModo_q;
    logic [WIDTH-1:0] pD_q;
    logic [WIDTH-1:0] pQ_q;
    logic             errQ_q, errQ_d;
    logic             errRco_q, errRco_d;
    logic             sticky_q, sticky_d;
    logic [ERR_W-1:0] errCnt_q, errCnt_d;
    logic [ERR_W-1:0] chkCnt_q, chkCnt_d;

    logic [WIDTH:0]   sum3;
    logic [WIDTH-1:0] expQ;
    logic             expRco;
    logic             checking;
    logic             qMis;
    logic             rcoMis;

    // The carry out of the widened Q+3 is exactly the "Q+3 > max" condition.
    assign sum3 = {1'b0, pQ_q} + (WIDTH+1)'(3);

    always_comb begin
        expQ   = pQ_q;
        expRco = 1'b0;
        if (pEnb_q) begin
            case (pModo_q)
                2'b00: begin
                    expQ   = sum3[WIDTH-1:0];
                    expRco = sum3[WIDTH];
                end
                2'b01: begin
                    expQ   = pQ_q - WIDTH'(1);
                    expRco = (pQ_q == '0);
                end
                2'b10: begin
                    expQ   = pQ_q + WIDTH'(1);
                    expRco = (pQ_q == MAX_Q);
                end
                default: begin
                    expQ   = pD_q;
                    expRco = 1'b0;
                end
            endcase
        end
    end

    // Case inequality makes an unknown Q/RCO count as a mismatch.
    assign checking = (state_q != IDLE);
    assign qMis     = (Q !== expQ);
    assign rcoMis   = (RCO !== expRco);

    always_comb begin
        state_d  = state_q;
        errQ_d   = checking & qMis;
        errRco_d = checking & rcoMis;
        sticky_d = sticky_q | errQ_d | errRco_d;
        errCnt_d = errCnt_q;
        chkCnt_d = chkCnt_q;

        case (state_q)
            IDLE:    state_d = WARM;
            WARM:    state_d = CHECK;
            CHECK:   state_d = CHECK;
            default: state_d = IDLE;
        endcase

        if (checking && (chkCnt_q != CNT_MAX)) begin
            chkCnt_d = chkCnt_q + ERR_W'(1);
        end
        if ((errQ_d || errRco_d) && (errCnt_q != CNT_MAX)) begin
            errCnt_d = errCnt_q + ERR_W'(1);
        end
    end

    // History always tracks the observed bus, so one fault yields one ERR.
    always_ff @(posedge CLK) begin
        if (!RESET_L) begin
            state_q  <= IDLE;
            pEnb_q   <= 1'b0;
            pModo_q  <= 2'b00;
            pD_q     <= '0;
            pQ_q     <= '0;
            errQ_q   <= 1'b0;
            errRco_q <= 1'b0;
            sticky_q <= 1'b0;
            errCnt_q <= '0;
            chkCnt_q <= '0;
        end else begin
            state_q  <= state_d;
            pEnb_q   <= ENB;
            pModo_q  <= MODO;
            pD_q     <= D;
            pQ_q     <= Q;
            errQ_q   <= errQ_d;
            errRco_q <= errRco_d;
            sticky_q <= sticky_d;
            errCnt_q <= errCnt_d;
            chkCnt_q <= chkCnt_d;
        end
    end

    assign ARMED      = (state_q != IDLE);
    assign ERR        = errQ_q | errRco_q;
    assign ERR_Q      = errQ_q;
    assign ERR_RCO    = errRco_q;
    assign ERR_STICKY = sticky_q;
    assign ERR_CNT    = errCnt_q;
    assign CHK_CNT    = chkCnt_q;
    assign EXP_Q      = expQ;

endmodule

// File: tb/tb_contador_monitor.sv
// Bench for contador_monitor: table of bus vectors with hand-derived expected
// outputs, queued as they are driven and compared after each rising edge.
module tb_contador_monitor;

    typedef struct {
        logic       rstL;
        logic       enb;
        logic [1:0] modo;
        logic [3:0] d;
        logic [3:0] q;
        logic       rco;
        logic       armed;
        logic       err;
        logic       errQ;
        logic       errRco;
        logic       sticky;
        int         errCnt;
        int         chkCnt;
        logic [3:0] expQ;
    } vec_t;

    logic       clock;
    logic       resetL;
    logic       enb;
    logic [1:0] modo;
    logic [3:0] d;
    logic [3:0] q;
    logic       rco;

    logic       armed, err, errQ, errRco, sticky;
    logic [7:0] errCnt, chkCnt;
    logic [3:0] expQ;

    logic       armed2, err2, errQ2, errRco2, sticky2;
    logic [1:0] errCnt2, chkCnt2;
    logic [3:0] expQ2;

    int   compared;
    int   mismatched;
    int   rowNum;
    vec_t vecs[$];
    vec_t expQueue[$];

    contador_monitor #(.WIDTH(4), .ERR_W(8)) dut (
        .CLK(clock), .RESET_L(resetL), .ENB(enb), .MODO(modo), .D(d), .Q(q), .RCO(rco),
        .ARMED(armed), .ERR(err), .ERR_Q(errQ), .ERR_RCO(errRco), .ERR_STICKY(sticky),
        .ERR_CNT(errCnt), .CHK_CNT(chkCnt), .EXP_Q(expQ)
    );

    // Narrow-counter copy sharing the same bus, to observe saturation at 3.
    contador_monitor #(.WIDTH(4), .ERR_W(2)) dut2 (
        .CLK(clock), .RESET_L(resetL), .ENB(enb), .MODO(modo), .D(d), .Q(q), .RCO(rco),
        .ARMED(armed2), .ERR(err2), .ERR_Q(errQ2), .ERR_RCO(errRco2), .ERR_STICKY(sticky2),
        .ERR_CNT(errCnt2), .CHK_CNT(chkCnt2), .EXP_Q(expQ2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(input logic r, input logic e, input logic [1:0] m,
                                input logic [3:0] dd, input logic [3:0] qq, input logic rc,
                                input logic a, input logic er, input logic eq, input logic erc,
                                input logic st, input int ec, input int cc, input logic [3:0] xq);
        vec_t v;
        v.rstL = r;  v.enb = e;   v.modo = m;   v.d = dd;   v.q = qq;   v.rco = rc;
        v.armed = a; v.err = er;  v.errQ = eq;  v.errRco = erc; v.sticky = st;
        v.errCnt = ec; v.chkCnt = cc; v.expQ = xq;
        return v;
    endfunction

    task automatic compareOne(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clock);
        resetL = v.rstL;
        enb    = v.enb;
        modo   = v.modo;
        d      = v.d;
        q      = v.q;
        rco    = v.rco;
        expQueue.push_back(v);
    endtask

    task automatic checkOutput();
        vec_t e;
        string tag;
        @(posedge clock);
        #1;
        if (expQueue.size() == 0) begin
            compareOne("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = expQueue.pop_front();
        tag = $sformatf("row%0d", rowNum);
        compareOne({tag, "_ARMED"},      32'(armed),   32'(e.armed));
        compareOne({tag, "_ERR"},        32'(err),     32'(e.err));
        compareOne({tag, "_ERR_Q"},      32'(errQ),    32'(e.errQ));
        compareOne({tag, "_ERR_RCO"},    32'(errRco),  32'(e.errRco));
        compareOne({tag, "_ERR_STICKY"}, 32'(sticky),  32'(e.sticky));
        compareOne({tag, "_ERR_CNT"},    32'(errCnt),  32'(e.errCnt));
        compareOne({tag, "_CHK_CNT"},    32'(chkCnt),  32'(e.chkCnt));
        compareOne({tag, "_EXP_Q"},      32'(expQ),    32'(e.expQ));
        compareOne({tag, "_ERR_CNT_w2"}, 32'(errCnt2), 32'((e.errCnt > 3) ? 3 : e.errCnt));
        compareOne({tag, "_CHK_CNT_w2"}, 32'(chkCnt2), 32'((e.chkCnt > 3) ? 3 : e.chkCnt));
        rowNum++;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rowNum     = 0;
        resetL = 1'b0; enb = 1'b0; modo = 2'b00; d = 4'd0; q = 4'd0; rco = 1'b0;

        //            rst enb modo   d     q     rco  arm err eQ eR st ec cc expQ
        // reset, then load 5 and count up 5..9
        vecs.push_back(mk(0, 0, 2'b00, 4'd0,  4'd0,  0,  0, 0, 0, 0, 0, 0, 0,  4'd0));
        vecs.push_back(mk(1, 1, 2'b11, 4'd5,  4'd0,  0,  1, 0, 0, 0, 0, 0, 0,  4'd5));
        vecs.push_back(mk(1, 1, 2'b10, 4'd5,  4'd5,  0,  1, 0, 0, 0, 0, 0, 1,  4'd6));
        vecs.push_back(mk(1, 1, 2'b10, 4'd5,  4'd6,  0,  1, 0, 0, 0, 0, 0, 2,  4'd7));
        vecs.push_back(mk(1, 1, 2'b10, 4'd5,  4'd7,  0,  1, 0, 0, 0, 0, 0, 3,  4'd8));
        vecs.push_back(mk(1, 1, 2'b10, 4'd5,  4'd8,  0,  1, 0, 0, 0, 0, 0, 4,  4'd9));
        // load 14, +3 wraps to 1 with RCO, then a forced bad Q
        vecs.push_back(mk(1, 1, 2'b11, 4'd14, 4'd9,  0,  1, 0, 0, 0, 0, 0, 5,  4'd14));
        vecs.push_back(mk(1, 1, 2'b00, 4'd0,  4'd14, 0,  1, 0, 0, 0, 0, 0, 6,  4'd1));
        vecs.push_back(mk(1, 1, 2'b00, 4'd0,  4'd1,  1,  1, 0, 0, 0, 0, 0, 7,  4'd4));
        vecs.push_back(mk(1, 1, 2'b10, 4'd0,  4'd2,  0,  1, 1, 1, 0, 1, 1, 8,  4'd3));
        vecs.push_back(mk(1, 1, 2'b11, 4'd0,  4'd3,  0,  1, 0, 0, 0, 1, 1, 9,  4'd0));
        // count down from 0: 15 with RCO, then forced missing RCO
        vecs.push_back(mk(1, 1, 2'b01, 4'd0,  4'd0,  0,  1, 0, 0, 0, 1, 1, 10, 4'd15));
        vecs.push_back(mk(1, 1, 2'b11, 4'd0,  4'd15, 1,  1, 0, 0, 0, 1, 1, 11, 4'd0));
        vecs.push_back(mk(1, 1, 2'b01, 4'd0,  4'd0,  0,  1, 0, 0, 0, 1, 1, 12, 4'd15));
        vecs.push_back(mk(1, 1, 2'b11, 4'd9,  4'd15, 0,  1, 1, 0, 1, 1, 2, 13, 4'd9));
        // disabled: Q held at 9, then five consecutive drifting faults
        vecs.push_back(mk(1, 0, 2'b10, 4'd0,  4'd9,  0,  1, 0, 0, 0, 1, 2, 14, 4'd9));
        vecs.push_back(mk(1, 0, 2'b10, 4'd0,  4'd9,  0,  1, 0, 0, 0, 1, 2, 15, 4'd9));
        vecs.push_back(mk(1, 0, 2'b10, 4'd0,  4'd9,  0,  1, 0, 0, 0, 1, 2, 16, 4'd9));
        vecs.push_back(mk(1, 0, 2'b10, 4'd0,  4'd10, 0,  1, 1, 1, 0, 1, 3, 17, 4'd10));
        vecs.push_back(mk(1, 0, 2'b10, 4'd0,  4'd11, 0,  1, 1, 1, 0, 1, 4, 18, 4'd11));
        vecs.push_back(mk(1, 0, 2'b10, 4'd0,  4'd12, 0,  1, 1, 1, 0, 1, 5, 19, 4'd12));
        vecs.push_back(mk(1, 0, 2'b10, 4'd0,  4'd13, 0,  1, 1, 1, 0, 1, 6, 20, 4'd13));
        vecs.push_back(mk(1, 0, 2'b10, 4'd0,  4'd14, 0,  1, 1, 1, 0, 1, 7, 21, 4'd14));
        vecs.push_back(mk(1, 0, 2'b10, 4'd0,  4'd14, 0,  1, 0, 0, 0, 1, 7, 22, 4'd14));
        // wrap edges: 13+3 -> 0 RCO=1, 12+3 -> 15 RCO=0, 15+1 -> 0 RCO=1
        vecs.push_back(mk(1, 1, 2'b11, 4'd13, 4'd14, 0,  1, 0, 0, 0, 1, 7, 23, 4'd13));
        vecs.push_back(mk(1, 1, 2'b00, 4'd0,  4'd13, 0,  1, 0, 0, 0, 1, 7, 24, 4'd0));
        vecs.push_back(mk(1, 1, 2'b11, 4'd12, 4'd0,  1,  1, 0, 0, 0, 1, 7, 25, 4'd12));
        vecs.push_back(mk(1, 1, 2'b00, 4'd0,  4'd12, 0,  1, 0, 0, 0, 1, 7, 26, 4'd15));
        vecs.push_back(mk(1, 1, 2'b10, 4'd0,  4'd15, 0,  1, 0, 0, 0, 1, 7, 27, 4'd0));
        vecs.push_back(mk(1, 1, 2'b10, 4'd0,  4'd0,  1,  1, 0, 0, 0, 1, 7, 28, 4'd1));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput();
        end

        // Reset mid-CHECK with sticky set; the first edge after release must not
        // check (garbage Q/RCO ignored), the second must (bad Q caught).
        applyStimulus(mk(0, 1, 2'b10, 4'd0, 4'd1, 0,  0, 0, 0, 0, 0, 0, 0, 4'd0));
        checkOutput();
        applyStimulus(mk(1, 1, 2'b11, 4'd7, 4'd3, 1,  1, 0, 0, 0, 0, 0, 0, 4'd7));
        checkOutput();
        applyStimulus(mk(1, 1, 2'b10, 4'd7, 4'd8, 0,  1, 1, 1, 0, 1, 1, 1, 4'd9));
        checkOutput();
        applyStimulus(mk(1, 1, 2'b10, 4'd7, 4'd9, 0,  1, 0, 0, 0, 1, 1, 2, 4'd10));
        checkOutput();

        if (expQueue.size() != 0) begin
            compareOne("scoreboard_leftover", 32'(expQueue.size()), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
